// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares one synchronous single-port data SRAM between the CPU stage-2
//   load/store path and the debug/loader port. One access is issued per
//   cycle. The CPU normally has priority. A wait counter bounds how long the
//   debug port can be starved. While the CPU is halted, the debug port owns
//   the memory outright. Read data comes back one cycle after the grant and is
//   steered to whichever port issued the read.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   cpu_halted            debug port gets absolute priority
//   cpu_req/we/addr/wdata CPU request (held until cpu_gnt)
//   cpu_gnt, cpu_stall    CPU issue this cycle / pipeline freeze (comb.)
//   cpu_rvalid, cpu_rdata CPU load return
//   dbg_req/we/addr/wdata debug request (held until dbg_gnt)
//   dbg_gnt               debug issue this cycle (comb.)
//   dbg_rvalid, dbg_rdata debug read return
//   mem_en/we/addr/wdata  SRAM command, driven by the winner, zero when idle
//   mem_rdata             SRAM read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_halted,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic {CPU_PRI, DBG_FORCE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;
  owner_t        rd_owner;
  logic [DW-1:0] cpu_rdata_hold;
  logic [DW-1:0] dbg_rdata_hold;

  // Grant selection. In DBG_FORCE the CPU is held off for one cycle, even
  // when the debug request has been withdrawn. Grants are also forced low
  // while reset is held.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (reset) begin
      if (cpu_halted || state == DBG_FORCE) begin
        dbg_gnt = dbg_req;
      end else begin
        cpu_gnt = cpu_req;
        dbg_gnt = dbg_req & ~cpu_req;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign mem_en    = cpu_gnt | dbg_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= CPU_PRI;
      starve_cnt     <= '0;
      rd_owner       <= OWN_NONE;
      cpu_rdata_hold <= '0;
      dbg_rdata_hold <= '0;
    end else begin
      // DBG_FORCE lasts exactly one cycle, whether or not debug is granted.
      if (cpu_halted || state == DBG_FORCE) begin
        state      <= CPU_PRI;
        starve_cnt <= '0;
      end else if (dbg_req && !dbg_gnt) begin
        if (starve_cnt >= LIMIT - CW'(1)) begin
          starve_cnt <= LIMIT;
          state      <= DBG_FORCE;
        end else begin
          starve_cnt <= starve_cnt + CW'(1);
        end
      end else begin
        starve_cnt <= '0;
      end

      if (cpu_gnt && !cpu_we)      rd_owner <= OWN_CPU;
      else if (dbg_gnt && !dbg_we) rd_owner <= OWN_DBG;
      else                         rd_owner <= OWN_NONE;

      // Keep the last delivered word so each rdata port holds its value
      // while the other owner is being served.
      if (rd_owner == OWN_CPU) cpu_rdata_hold <= mem_rdata;
      if (rd_owner == OWN_DBG) dbg_rdata_hold <= mem_rdata;
    end
  end

  // The SRAM output register supplies the data in the cycle after the grant.
  // It is passed straight through to the owner in that cycle.
  assign cpu_rvalid = (rd_owner == OWN_CPU);
  assign dbg_rvalid = (rd_owner == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_hold;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_rdata_hold;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
//   Self-checking bench for dmem_port_arbiter with a write-first SRAM model.
//   Directed scenarios are followed by randomized traffic. The random traffic
//   is checked against a transaction-level reference that uses a
//   "consecutive debug denials" run length and a shadow memory.
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_halted = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt, cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] sram    [0:65535];
  logic [DW-1:0] ref_mem [0:65535];

  int n_checks = 0;
  int n_pass   = 0;

  dmem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .cpu_halted(cpu_halted),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Write-first synchronous SRAM
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        sram[mem_addr] <= mem_wdata;
        mem_rdata      <= mem_wdata;
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  // Apply one cycle of inputs just after a rising edge. Return mid-cycle,
  // where comb grants and the previous cycle's read return are both stable.
  task automatic step(input logic h, input logic cr, input logic cw,
                      input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                      input logic dr, input logic dw,
                      input logic [AW-1:0] da, input logic [DW-1:0] dd);
    @(posedge clk); #1;
    cpu_halted = h;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    #3;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    cpu_req = 1'b1; dbg_req = 1'b1; cpu_addr = 16'h0003; dbg_addr = 16'h0004;
    #22;
    n_checks++;
    if ({cpu_gnt, dbg_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== '0)
      $display("FAIL reset_grants: got gnt=%b%b en=%b we=%b addr=%h wd=%h want all 0",
               cpu_gnt, dbg_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    else n_pass++;
    n_checks++;
    if ({cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata} !== '0)
      $display("FAIL reset_read: got rv=%b%b crd=%h drd=%h want all 0",
               cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata);
    else n_pass++;
    cpu_req = 1'b0; dbg_req = 1'b0;
    reset = 1'b1;
    idle();
    $display("test_reset done");
  endtask

  task automatic test_cpu_read();
    sram[16'h0010] = 16'hBEEF;
    step(1'b0, 1'b1, 1'b0, 16'h0010, '0, 1'b0, 1'b0, '0, '0);
    n_checks++;
    if ({cpu_gnt, cpu_stall, mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 16'h0010})
      $display("FAIL cpu_read_issue: got gnt=%b stall=%b en=%b we=%b addr=%h want 1 0 1 0 0010",
               cpu_gnt, cpu_stall, mem_en, mem_we, mem_addr);
    else n_pass++;
    idle();
    n_checks++;
    if ({cpu_rvalid, dbg_rvalid, cpu_rdata} !== {1'b1, 1'b0, 16'hBEEF})
      $display("FAIL cpu_read_data: got rv=%b drv=%b rd=%h want 1 0 beef", cpu_rvalid, dbg_rvalid, cpu_rdata);
    else n_pass++;
    idle();
    n_checks++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b0, 16'hBEEF})
      $display("FAIL cpu_read_hold: got rv=%b rd=%h want 0 beef", cpu_rvalid, cpu_rdata);
    else n_pass++;
    $display("test_cpu_read done");
  endtask

  task automatic test_contention();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0020, '0, 1'b1, 1'b0, 16'h0021, '0);
      n_checks++;
      if ({cpu_gnt, dbg_gnt, cpu_stall} !== ((i == 4) ? 3'b011 : 3'b100))
        $display("FAIL contention_cycle%0d: got cgnt=%b dgnt=%b stall=%b want %b",
                 i, cpu_gnt, dbg_gnt, cpu_stall, (i == 4) ? 3'b011 : 3'b100);
      else n_pass++;
    end
    idle();
    $display("test_contention done");
  endtask

  task automatic test_halt();
    step(1'b1, 1'b1, 1'b0, 16'h0030, '0, 1'b1, 1'b1, 16'h0002, 16'h1234);
    n_checks++;
    if ({cpu_gnt, dbg_gnt, cpu_stall, mem_we, mem_addr, mem_wdata} !==
        {1'b0, 1'b1, 1'b1, 1'b1, 16'h0002, 16'h1234})
      $display("FAIL halt_write: got cg=%b dg=%b st=%b we=%b a=%h d=%h want 0 1 1 1 0002 1234",
               cpu_gnt, dbg_gnt, cpu_stall, mem_we, mem_addr, mem_wdata);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'h0030, '0, 1'b1, 1'b0, 16'h0002, '0);
      n_checks++;
      if ({cpu_gnt, dbg_gnt, cpu_stall} !== 3'b011)
        $display("FAIL halt_cycle%0d: got cg=%b dg=%b st=%b want 011", i, cpu_gnt, dbg_gnt, cpu_stall);
      else n_pass++;
    end
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    n_checks++;
    if ({dbg_rvalid, cpu_rvalid, dbg_rdata} !== {1'b1, 1'b0, 16'h1234})
      $display("FAIL halt_read: got drv=%b crv=%b drd=%h want 1 0 1234", dbg_rvalid, cpu_rvalid, dbg_rdata);
    else n_pass++;
    idle();
    $display("test_halt done");
  endtask

  task automatic test_interleaved();
    sram[1] = 16'hAAAA; sram[2] = 16'hBBBB; sram[3] = 16'hCCCC;
    step(1'b0, 1'b1, 1'b0, 16'h0001, '0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0002, '0);
    n_checks++;
    if ({cpu_rvalid, dbg_rvalid, cpu_rdata} !== {1'b1, 1'b0, 16'hAAAA})
      $display("FAIL inter_cpu1: got crv=%b drv=%b crd=%h want 1 0 aaaa", cpu_rvalid, dbg_rvalid, cpu_rdata);
    else n_pass++;
    step(1'b0, 1'b1, 1'b0, 16'h0003, '0, 1'b0, 1'b0, '0, '0);
    n_checks++;
    if ({cpu_rvalid, dbg_rvalid, dbg_rdata, cpu_rdata} !== {1'b0, 1'b1, 16'hBBBB, 16'hAAAA})
      $display("FAIL inter_dbg2: got crv=%b drv=%b drd=%h crd=%h want 0 1 bbbb aaaa",
               cpu_rvalid, dbg_rvalid, dbg_rdata, cpu_rdata);
    else n_pass++;
    idle();
    n_checks++;
    if ({cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata} !== {1'b1, 1'b0, 16'hCCCC, 16'hBBBB})
      $display("FAIL inter_cpu3: got crv=%b drv=%b crd=%h drd=%h want 1 0 cccc bbbb",
               cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata);
    else n_pass++;
    $display("test_interleaved done");
  endtask

  task automatic test_raw();
    sram[5] = 16'h0000;
    step(1'b0, 1'b1, 1'b1, 16'h0005, 16'h00FF, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, 16'h0005, '0, 1'b0, 1'b0, '0, '0);
    n_checks++;
    if (cpu_rvalid !== 1'b0)
      $display("FAIL raw_no_write_rvalid: got %b want 0", cpu_rvalid);
    else n_pass++;
    idle();
    n_checks++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 16'h00FF})
      $display("FAIL raw_data: got rv=%b rd=%h want 1 00ff", cpu_rvalid, cpu_rdata);
    else n_pass++;
    $display("test_raw done");
  endtask

  task automatic test_reset_midread();
    // Build up three debug denials, then issue a read and reset before it returns.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b1, 16'h0040, 16'h0001, 1'b1, 1'b0, 16'h0041, '0);
    step(1'b0, 1'b1, 1'b0, 16'h0010, '0, 1'b1, 1'b0, 16'h0011, '0);
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({cpu_rvalid, dbg_rvalid, cpu_gnt, dbg_gnt, mem_en} !== 5'b0)
      $display("FAIL midread_reset: got crv=%b drv=%b cg=%b dg=%b en=%b want 0",
               cpu_rvalid, dbg_rvalid, cpu_gnt, dbg_gnt, mem_en);
    else n_pass++;
    cpu_req = 1'b0; dbg_req = 1'b0;
    #4 reset = 1'b1;
    idle();
    n_checks++;
    if ({cpu_rvalid, dbg_rvalid} !== 2'b00)
      $display("FAIL midread_after: got crv=%b drv=%b want 00", cpu_rvalid, dbg_rvalid);
    else n_pass++;
    // A cleared wait counter gives the CPU a full run of LIM grants again.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0050, '0, 1'b1, 1'b0, 16'h0051, '0);
      n_checks++;
      if ({cpu_gnt, dbg_gnt} !== ((i == LIM) ? 2'b01 : 2'b10))
        $display("FAIL midread_restart%0d: got cg=%b dg=%b want %b",
                 i, cpu_gnt, dbg_gnt, (i == LIM) ? 2'b01 : 2'b10);
      else n_pass++;
    end
    idle();
    $display("test_reset_midread done");
  endtask

  task automatic test_random();
    int run = 0;          // consecutive cycles DBG has wanted and not received the memory
    int pend = 0;         // 0 none, 1 cpu, 2 dbg: owner of the read issued last cycle
    logic [DW-1:0] pend_data = '0;
    logic h = 1'b0, cr = 1'b0, cw = 1'b0, dr = 1'b0, dw = 1'b0;
    logic [AW-1:0] ca = '0, da = '0;
    logic [DW-1:0] cd = '0, dd = '0;
    int w;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic wwe;
    logic [2*DW+4:0] exp_vec, got_vec;
    for (int a = 0; a < 16; a++) begin
      sram[a] = 16'($urandom);
      ref_mem[a] = sram[a];
    end
    idle();
    for (int n = 0; n < 400; n++) begin
      h = ($urandom_range(9) == 0);
      if (!cr && $urandom_range(9) < 6) begin
        cr = 1'b1; cw = 1'($urandom); ca = 16'($urandom_range(15)); cd = 16'($urandom);
      end
      if (!dr && $urandom_range(9) < 4) begin
        dr = 1'b1; dw = 1'($urandom); da = 16'($urandom_range(15)); dd = 16'($urandom);
      end
      if (h || run >= LIM) w = dr ? 2 : 0;
      else                 w = cr ? 1 : (dr ? 2 : 0);
      wwe = (w == 1) ? cw : (w == 2) ? dw : 1'b0;
      wa  = (w == 1) ? ca : (w == 2) ? da : '0;
      wd  = (w == 1) ? cd : (w == 2) ? dd : '0;
      step(h, cr, cw, ca, cd, dr, dw, da, dd);
      exp_vec = {w == 1, w == 2, cr && w != 1, w != 0, wwe, wa, wd};
      got_vec = {cpu_gnt, dbg_gnt, cpu_stall, mem_en, mem_we, mem_addr, mem_wdata};
      n_checks++;
      if (got_vec !== exp_vec)
        $display("FAIL rand_issue%0d: got %h want %h", n, got_vec, exp_vec);
      else n_pass++;
      n_checks++;
      if ({cpu_rvalid, dbg_rvalid} !== {pend == 1, pend == 2})
        $display("FAIL rand_rvalid%0d: got %b%b want %b%b", n, cpu_rvalid, dbg_rvalid, pend == 1, pend == 2);
      else n_pass++;
      if (pend != 0) begin
        n_checks++;
        if (((pend == 1) ? cpu_rdata : dbg_rdata) !== pend_data)
          $display("FAIL rand_rdata%0d: got %h want %h", n, (pend == 1) ? cpu_rdata : dbg_rdata, pend_data);
        else n_pass++;
      end
      pend = 0;
      if (w != 0) begin
        if (wwe) ref_mem[wa] = wd;
        else begin pend = w; pend_data = ref_mem[wa]; end
      end
      if (h || !dr || w == 2) run = 0;
      else if (run < LIM)     run = run + 1;
      if (w == 1) cr = 1'b0;
      if (w == 2) dr = 1'b0;
    end
    idle();
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_contention();
    test_halt();
    test_interleaved();
    test_raw();
    test_reset_midread();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
